// File: rtl/can_bit_destuff.sv
// can_bit_destuff
//   Removes CAN stuff bits from the sampled bit stream that comes out of the
//   bit timing logic. The stream then goes on to the bit stream processor.
//   The block supports two kinds of stuffing:
//     - dynamic: a complement bit follows every RUN_LEN equal bits;
//     - fixed (FD CRC field): a complement bit comes first, then one follows
//       every FIX_LEN data bits.
//   It flags stuff-rule violations. It also keeps the modulo-8 count of
//   removed dynamic stuff bits in binary, Gray and parity form, which is
//   needed to check the FD stuff-count field.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   sample_point    one-clk strobe, sampled_bit is valid
//   sampled_bit     bus value at the sample point
//   hard_sync       SOF pulse, clears all state including the stuff count
//   go_error_frame  clears run/fixed state, keeps the stuff count
//   destuff_en      stuffing active; when low, bits pass straight through
//   fixed_stuff     level, FD CRC field with fixed stuffing
//   bit_valid       one-clk pulse, bit_out carries a data bit
//   bit_out         destuffed data bit (held between pulses)
//   stuff_bit       one-clk pulse, a correct stuff bit was removed
//   stuff_err       one-clk pulse, stuff rule violated
//   stuff_cnt       dynamic stuff bits removed since SOF, mod 8
//   stuff_cnt_gray  Gray code of stuff_cnt
//   stuff_parity    XOR of the stuff_cnt_gray bits
module can_bit_destuff #(
    parameter int          Tp      = 1,
    parameter int unsigned RUN_LEN = 5,
    parameter int unsigned FIX_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_point,
    input  logic       sampled_bit,
    input  logic       hard_sync,
    input  logic       go_error_frame,
    input  logic       destuff_en,
    input  logic       fixed_stuff,
    output logic       bit_valid,
    output logic       bit_out,
    output logic       stuff_bit,
    output logic       stuff_err,
    output logic [2:0] stuff_cnt,
    output logic [2:0] stuff_cnt_gray,
    output logic       stuff_parity
);

    // Tp is kept as a parameter so existing instantiations still work. The
    // logic itself contains no delays. The counters are 3 bits wide, so both
    // lengths must fit in 1..7.
    if (RUN_LEN < 1 || RUN_LEN > 7 || FIX_LEN < 1 || FIX_LEN > 7 || Tp < 0) begin : g_bad_param
        $error("can_bit_destuff: RUN_LEN/FIX_LEN must be 1..7 and Tp non-negative");
    end

    localparam logic [2:0] RUN_LIM = 3'(RUN_LEN);
    localparam logic [2:0] FIX_LIM = 3'(FIX_LEN);

    logic       prev;
    logic [2:0] run_cnt;
    logic [2:0] fix_cnt;
    logic       fix_q;
    logic       cnt_frozen;

    logic       same_bit;
    logic       run_full;
    logic       fix_slot;
    logic [2:0] cnt_inc;
    logic [2:0] gray_inc;

    always_comb begin
        same_bit = (sampled_bit == prev);
        run_full = (run_cnt == RUN_LIM);
        // The first bit after entering fixed mode is always a stuff bit.
        fix_slot = !fix_q || (fix_cnt == FIX_LIM);
        cnt_inc  = stuff_cnt + 3'd1;
        gray_inc = cnt_inc ^ (cnt_inc >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_valid      <= 1'b0;
            bit_out        <= 1'b1;
            stuff_bit      <= 1'b0;
            stuff_err      <= 1'b0;
            stuff_cnt      <= '0;
            stuff_cnt_gray <= '0;
            stuff_parity   <= 1'b0;
            prev           <= 1'b1;
            run_cnt        <= '0;
            fix_cnt        <= '0;
            fix_q          <= 1'b0;
            cnt_frozen     <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            stuff_bit <= 1'b0;
            stuff_err <= 1'b0;

            if (hard_sync || go_error_frame) begin
                prev    <= 1'b1;
                run_cnt <= '0;
                fix_cnt <= '0;
                fix_q   <= 1'b0;
                if (hard_sync) begin
                    stuff_cnt      <= '0;
                    stuff_cnt_gray <= '0;
                    stuff_parity   <= 1'b0;
                    cnt_frozen     <= 1'b0;
                end
            end else if (sample_point) begin
                fix_q <= destuff_en & fixed_stuff;

                if (!destuff_en) begin
                    bit_valid <= 1'b1;
                    bit_out   <= sampled_bit;
                    run_cnt   <= '0;
                    prev      <= 1'b1;
                    fix_cnt   <= '0;
                end else if (fixed_stuff) begin
                    // Fixed stuff bits are not counted. The count is also
                    // frozen from here until the next SOF.
                    cnt_frozen <= 1'b1;
                    run_cnt    <= '0;
                    prev       <= sampled_bit;
                    if (fix_slot) begin
                        fix_cnt <= '0;
                        if (!same_bit) stuff_bit <= 1'b1;
                        else           stuff_err <= 1'b1;
                    end else begin
                        bit_valid <= 1'b1;
                        bit_out   <= sampled_bit;
                        fix_cnt   <= fix_cnt + 3'd1;
                    end
                end else if (run_full) begin
                    // Stuff slot: the stuff bit itself opens the next run.
                    run_cnt <= 3'd1;
                    prev    <= sampled_bit;
                    if (!same_bit) begin
                        stuff_bit <= 1'b1;
                        if (!cnt_frozen) begin
                            stuff_cnt      <= cnt_inc;
                            stuff_cnt_gray <= gray_inc;
                            stuff_parity   <= ^gray_inc;
                        end
                    end else begin
                        stuff_err <= 1'b1;
                    end
                end else begin
                    bit_valid <= 1'b1;
                    bit_out   <= sampled_bit;
                    run_cnt   <= same_bit ? run_cnt + 3'd1 : 3'd1;
                    prev      <= sampled_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_bit_destuff.sv
module tb_can_bit_destuff;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_point;
    logic       sampled_bit;
    logic       hard_sync;
    logic       go_error_frame;
    logic       destuff_en;
    logic       fixed_stuff;
    logic       bit_valid;
    logic       bit_out;
    logic       stuff_bit;
    logic       stuff_err;
    logic [2:0] stuff_cnt;
    logic [2:0] stuff_cnt_gray;
    logic       stuff_parity;

    always #5 clk = ~clk;

    can_bit_destuff #(
        .Tp      (1),
        .RUN_LEN (5),
        .FIX_LEN (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_point   (sample_point),
        .sampled_bit    (sampled_bit),
        .hard_sync      (hard_sync),
        .go_error_frame (go_error_frame),
        .destuff_en     (destuff_en),
        .fixed_stuff    (fixed_stuff),
        .bit_valid      (bit_valid),
        .bit_out        (bit_out),
        .stuff_bit      (stuff_bit),
        .stuff_err      (stuff_err),
        .stuff_cnt      (stuff_cnt),
        .stuff_cnt_gray (stuff_cnt_gray),
        .stuff_parity   (stuff_parity)
    );

    typedef struct {
        string      name;
        logic       hs;
        logic       gef;
        logic       en;
        logic       fx;
        logic       sp;
        logic       b;
        logic       v;
        logic       s;
        logic       e;
        logic [2:0] cnt;
    } vec_t;

    vec_t       vecs[$];
    vec_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic       exp_out  = 1'b1;
    logic [2:0] gray_lut [8];
    logic       mode_en  = 1'b1;
    logic       mode_fx  = 1'b0;
    string      tag      = "";

    task automatic check(input string what, input logic v, input logic s, input logic e,
                         input logic [2:0] c);
        logic [2:0] g;
        logic       p;
        g = gray_lut[c];
        p = ^g;
        checks++;
        if ({bit_valid, stuff_bit, stuff_err, bit_out, stuff_cnt, stuff_cnt_gray, stuff_parity}
            !== {v, s, e, exp_out, c, g, p}) begin
            failures++;
            $display("FAIL %s: got valid=%b stuff=%b err=%b out=%b cnt=%0d gray=%b par=%b, want valid=%b stuff=%b err=%b out=%b cnt=%0d gray=%b par=%b",
                     what, bit_valid, stuff_bit, stuff_err, bit_out, stuff_cnt, stuff_cnt_gray,
                     stuff_parity, v, s, e, exp_out, c, g, p);
        end
    endtask

    function void add(input logic hs, input logic gef, input logic sp, input logic b,
                      input logic v, input logic s, input logic e, input logic [2:0] c);
        vec_t x;
        x.name = $sformatf("%s#%0d", tag, vecs.size());
        x.hs = hs; x.gef = gef; x.en = mode_en; x.fx = mode_fx; x.sp = sp; x.b = b;
        x.v = v; x.s = s; x.e = e; x.cnt = c;
        vecs.push_back(x);
    endfunction

    function void dat(input logic b, input logic [2:0] c);   add(1'b0, 1'b0, 1'b1, b, 1'b1, 1'b0, 1'b0, c); endfunction
    function void stf(input logic b, input logic [2:0] c);   add(1'b0, 1'b0, 1'b1, b, 1'b0, 1'b1, 1'b0, c); endfunction
    function void err(input logic b, input logic [2:0] c);   add(1'b0, 1'b0, 1'b1, b, 1'b0, 1'b0, 1'b1, c); endfunction
    function void hsync();                                   add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0); endfunction
    function void dats(input int n, input logic b, input logic [2:0] c);
        for (int i = 0; i < n; i++) dat(b, c);
    endfunction

    // SOF followed by n correct dynamic stuff bits, with alternating runs.
    function void stuff_frame(input int n);
        logic cur;
        hsync();
        cur = 1'b0;
        dats(5, cur, 3'd0);
        for (int k = 1; k <= n; k++) begin
            stf(~cur, 3'(k));
            cur = ~cur;
            if (k < n) dats(4, cur, 3'(k));
        end
    endfunction

    task automatic apply(input vec_t x);
        vec_t y;
        @(negedge clk);
        hard_sync      = x.hs;
        go_error_frame = x.gef;
        destuff_en     = x.en;
        fixed_stuff    = x.fx;
        sample_point   = x.sp;
        sampled_bit    = x.b;
        sb.push_back(x);
        @(posedge clk);
        #1;
        hard_sync      = 1'b0;
        go_error_frame = 1'b0;
        sample_point   = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: got empty queue, want one entry");
        end else begin
            y = sb.pop_front();
            if (y.v) exp_out = y.b;
            check(y.name, y.v, y.s, y.e, y.cnt);
            // Idle cycle: pulses low, bit_out and counters hold.
            @(posedge clk);
            #1;
            check({y.name, "/idle"}, 1'b0, 1'b0, 1'b0, y.cnt);
        end
    endtask

    task automatic run_table();
        for (int unsigned i = 0; i < vecs.size(); i++) apply(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        gray_lut = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        rst = 1'b1; sample_point = 1'b0; sampled_bit = 1'b1; hard_sync = 1'b0;
        go_error_frame = 1'b0; destuff_en = 1'b0; fixed_stuff = 1'b0;
        #12;
        check("reset", 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b0;

        // SOF + 4 zeros, then a correct stuff bit.
        tag = "sof5"; mode_en = 1'b1; mode_fx = 1'b0;
        hsync(); dats(5, 1'b0, 3'd0); stf(1'b1, 3'd1); dat(1'b1, 3'd1);

        // Six equal bits: the sixth is a stuff error and destuffing continues.
        tag = "run6";
        hsync(); dats(5, 1'b0, 3'd0); err(1'b0, 3'd0); dat(1'b1, 3'd0);

        tag = "wrap9";  stuff_frame(9);
        tag = "three";  stuff_frame(3);

        // Fixed stuffing entered with prev=0; the count is frozen afterwards.
        tag = "fixed";
        hsync(); dats(5, 1'b0, 3'd0); stf(1'b1, 3'd1); dat(1'b0, 3'd1);
        mode_fx = 1'b1;
        stf(1'b1, 3'd1);
        dat(1'b1, 3'd1); dat(1'b0, 3'd1); dat(1'b1, 3'd1); dat(1'b1, 3'd1);
        stf(1'b0, 3'd1);
        dat(1'b0, 3'd1); dat(1'b1, 3'd1); dat(1'b1, 3'd1); dat(1'b0, 3'd1);
        err(1'b0, 3'd1);
        dat(1'b1, 3'd1);
        mode_fx = 1'b0;
        dats(5, 1'b1, 3'd1);
        stf(1'b0, 3'd1);

        // hard_sync coincident with a sample point at run_cnt=4.
        tag = "midsync";
        hsync(); dats(5, 1'b0, 3'd0); stf(1'b1, 3'd1); dats(3, 1'b1, 3'd1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        dats(5, 1'b0, 3'd0); err(1'b0, 3'd0);

        // go_error_frame keeps the count but restarts the run.
        tag = "gef";
        hsync(); dats(5, 1'b0, 3'd0); stf(1'b1, 3'd1); dats(2, 1'b1, 3'd1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        dats(5, 1'b0, 3'd1); stf(1'b1, 3'd2);

        // Pass-through: eight dominant bits never produce stuff events.
        tag = "pass";
        hsync(); mode_en = 1'b0; dats(8, 1'b0, 3'd0); dat(1'b1, 3'd0); dat(1'b0, 3'd0);
        mode_en = 1'b1; dats(5, 1'b0, 3'd0); stf(1'b1, 3'd1); dat(1'b0, 3'd1);
        run_table();

        // Asynchronous reset mid-frame, with cnt=1 and bit_out=0 beforehand.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_out = 1'b1;
        check("async_rst", 1'b0, 1'b0, 1'b0, 3'd0);
        destuff_en = 1'b1; sample_point = 1'b1; sampled_bit = 1'b0;
        @(posedge clk);
        #1;
        sample_point = 1'b0;
        check("rst_held", 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b0;

        tag = "post_rst";
        dats(5, 1'b0, 3'd0); stf(1'b1, 3'd1);
        run_table();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
